// File: rtl/example_1_pkg.sv
// Shared constants and the reference evaluation of the D/E cell.
package example_1_pkg;

    localparam int NUM_COMBOS      = 8;
    localparam int MAX_PIPE_STAGES = 4;

    // Returns {D, E} for one input combination.
    function automatic logic [1:0] eval_d_e(input logic a, input logic b, input logic c);
        return {(a & b) | ~c, ~c};
    endfunction

endpackage

// File: rtl/example_1_logic.sv
// Pure gate network: d_comb = (a & b) | ~c, e_comb = ~c.
module example_1_logic (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d_comb,
    output logic e_comb
);

    logic w1;

    and u_and (w1, a, b);
    not u_not (e_comb, c);
    or  u_or  (d_comb, w1, e_comb);

endmodule

// File: rtl/example_1_circuit.sv
// D/E logic cell with a PIPE_STAGES-deep output pipeline and an input
// coverage tracker over the 8 {a,b,c} combinations.
module example_1_circuit
    import example_1_pkg::*;
#(
    parameter int PIPE_STAGES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       in_valid,
    output logic       d_comb,
    output logic       e_comb,
    output logic       d,
    output logic       e,
    output logic       out_valid,
    output logic [7:0] seen_mask,
    output logic       all_seen
);

    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_stages
            $error("example_1_circuit: PIPE_STAGES must be in 1..%0d", MAX_PIPE_STAGES);
        end
    endgenerate

    example_1_logic u_logic (
        .a      (a),
        .b      (b),
        .c      (c),
        .d_comb (d_comb),
        .e_comb (e_comb)
    );

    // Index 0 of each *_pipe view is the live input; 1..PIPE_STAGES are registers.
    logic [PIPE_STAGES:1] vld_q, d_q, e_q;
    logic [PIPE_STAGES:0] vld_pipe, d_pipe, e_pipe;

    assign vld_pipe = {vld_q, in_valid};
    assign d_pipe   = {d_q, d_comb};
    assign e_pipe   = {e_q, e_comb};

    // Unconditional shift every clock; data moves even when in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            d_q   <= '0;
            e_q   <= '0;
        end else begin
            vld_q <= vld_pipe[PIPE_STAGES-1:0];
            d_q   <= d_pipe[PIPE_STAGES-1:0];
            e_q   <= e_pipe[PIPE_STAGES-1:0];
        end
    end

    assign out_valid = vld_pipe[PIPE_STAGES];
    assign d         = d_pipe[PIPE_STAGES];
    assign e         = e_pipe[PIPE_STAGES];

    logic [NUM_COMBOS-1:0] seen_q;
    logic [2:0]            combo_idx;

    assign combo_idx = {a, b, c};

    // Sticky coverage: each valid sample sets the bit of its combination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
        end else if (in_valid) begin
            seen_q <= seen_q | (NUM_COMBOS'(1) << combo_idx);
        end
    end

    assign seen_mask = seen_q;
    assign all_seen  = &seen_q;

endmodule

// File: tb/tb_example_1_circuit.sv
// Self-checking bench: two instances (1 and 3 pipeline stages) share the
// stimulus and are compared against a truth-table / history-queue model.
module tb_example_1_circuit;
    import example_1_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, in_valid = 1'b0;

    logic       d_comb1, e_comb1, d1, e1, ov1, all1;
    logic [7:0] seen1;
    logic       d_comb3, e_comb3, d3, e3, ov3, all3;
    logic [7:0] seen3;

    always #5 clk = ~clk;

    example_1_circuit #(.PIPE_STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .in_valid(in_valid),
        .d_comb(d_comb1), .e_comb(e_comb1), .d(d1), .e(e1), .out_valid(ov1),
        .seen_mask(seen1), .all_seen(all1)
    );

    example_1_circuit #(.PIPE_STAGES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .in_valid(in_valid),
        .d_comb(d_comb3), .e_comb(e_comb3), .d(d3), .e(e3), .out_valid(ov3),
        .seen_mask(seen3), .all_seen(all3)
    );

    // {D,E} per index {a,b,c}, straight from the truth table.
    localparam logic [1:0] TT [8] = '{2'b11, 2'b00, 2'b11, 2'b00,
                                      2'b11, 2'b00, 2'b11, 2'b10};

    int checks = 0;
    int failures = 0;

    // Model state: history of samples {valid,D,E}, newest at front.
    logic [2:0] hist[$];
    logic [7:0] exp_seen;
    int         ov3_pulses;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back(3'b000);
        exp_seen = 8'h00;
    endtask

    task automatic check_comb(input logic [2:0] idx);
        logic [1:0] t;
        t = TT[idx];
        chk("d_comb1", {31'd0, d_comb1}, {31'd0, t[1]});
        chk("e_comb1", {31'd0, e_comb1}, {31'd0, t[0]});
        chk("d_comb3", {31'd0, d_comb3}, {31'd0, t[1]});
        chk("e_comb3", {31'd0, e_comb3}, {31'd0, t[0]});
    endtask

    task automatic check_regs();
        logic [2:0] s1, s3;
        s1 = hist[0];
        s3 = hist[2];
        chk("out_valid1", {31'd0, ov1}, {31'd0, s1[2]});
        chk("d1", {31'd0, d1}, {31'd0, s1[1]});
        chk("e1", {31'd0, e1}, {31'd0, s1[0]});
        chk("out_valid3", {31'd0, ov3}, {31'd0, s3[2]});
        chk("d3", {31'd0, d3}, {31'd0, s3[1]});
        chk("e3", {31'd0, e3}, {31'd0, s3[0]});
        chk("seen1", {24'd0, seen1}, {24'd0, exp_seen});
        chk("seen3", {24'd0, seen3}, {24'd0, exp_seen});
        chk("all_seen1", {31'd0, all1}, {31'd0, exp_seen == 8'hFF});
        chk("all_seen3", {31'd0, all3}, {31'd0, exp_seen == 8'hFF});
    endtask

    // Called right after a negedge: apply, check comb, clock, check regs.
    task automatic tick(input logic [2:0] idx, input logic v);
        {a, b, c} = idx;
        in_valid  = v;
        #1;
        check_comb(idx);
        @(posedge clk);
        hist.push_front({v, TT[idx]});
        void'(hist.pop_back());
        if (v) exp_seen[idx] = 1'b1;
        #1;
        check_regs();
        if (ov3) ov3_pulses++;
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic async_reset(input logic [2:0] idx);
        {a, b, c} = idx;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_comb(idx);
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        ov3_pulses = 0;
        #2;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;

        // Package helper agrees with the truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] ix;
            ix = 3'(i);
            chk("eval_d_e", {30'd0, eval_d_e(ix[2], ix[1], ix[0])}, {30'd0, TT[ix]});
        end

        // Partial coverage: 0, 2, 4 only.
        tick(3'd0, 1'b1);
        tick(3'd2, 1'b1);
        tick(3'd4, 1'b1);
        chk("partial_seen", {24'd0, seen1}, 32'h15);
        chk("partial_all", {31'd0, all1}, 32'd0);

        // Invalid index 5: no coverage, out_valid low, d/e still (0,0).
        tick(3'd5, 1'b0);
        tick(3'd5, 1'b0);
        tick(3'd5, 1'b0);
        chk("inval_bit5", {31'd0, seen3[5]}, 32'd0);
        chk("inval_d3", {31'd0, d3}, 32'd0);

        // Exhaustive sweep.
        for (int i = 0; i < 8; i++) tick(3'(i), 1'b1);
        chk("sweep_seen", {24'd0, seen1}, 32'hFF);
        chk("sweep_all", {31'd0, all3}, 32'd1);

        // Single valid pulse of index 6 through the 3-stage instance.
        for (int i = 0; i < 4; i++) tick(3'd1, 1'b0);
        ov3_pulses = 0;
        tick(3'd6, 1'b1);
        tick(3'd1, 1'b0);
        tick(3'd1, 1'b0);
        chk("lat3_ov", {31'd0, ov3}, 32'd1);
        chk("lat3_de", {30'd0, d3, e3}, 32'd3);
        tick(3'd1, 1'b0);
        tick(3'd1, 1'b0);
        chk("lat3_pulses", ov3_pulses, 1);

        // Back-to-back alternating 1 and 7.
        for (int i = 0; i < 10; i++) tick((i % 2) ? 3'd7 : 3'd1, 1'b1);

        // Async reset mid-sweep, then resume.
        tick(3'd0, 1'b1);
        tick(3'd1, 1'b1);
        tick(3'd2, 1'b1);
        async_reset(3'd3);
        chk("rst_seen", {24'd0, seen3}, 32'd0);
        for (int i = 3; i < 8; i++) tick(3'(i), 1'b1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) async_reset(3'($urandom_range(0, 7)));
            else tick(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
